lfu_victim_select: RTL and testbench

- Parameterised least-frequently-used replacement engine for one cache set with NUM_WAYS ways.
- Keeps one saturating access counter per way.
  - Incremented on hit.
  - Reinitialised on fill.
  - Aged by halving.
- On request, returns the way with the lowest count through a 2-stage pipelined minimum tree.
- Sits between the cache hit/fill logic and the refill controller.
- Successor to the fixed 4-way, combinational-count comparator; adds internal counter storage, aging and pipelining.

---
 rtl/lfu_victim_select.sv | 162 ++++++++++++++++
 tb/tb_lfu_victim_select.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfu_victim_select.sv
`default_nettype none
// ============================================================================
// Module      : lfu_victim_select
// Description : LFU replacement engine for one cache set. It keeps saturating
//               per-way counters with aging and uses a 2-stage min-tree to
//               select the victim way.
// Revision    : 1.0 - initial release
// ============================================================================
module lfu_victim_select #(
    parameter int NUM_WAYS   = 4,
    parameter int CNT_W      = 4,
    parameter int AGE_PERIOD = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          hit_valid,
    input  logic [$clog2(NUM_WAYS)-1:0]   hit_way,
    input  logic                          fill_valid,
    input  logic [$clog2(NUM_WAYS)-1:0]   fill_way,
    input  logic                          victim_req,
    output logic                          victim_valid,
    output logic [$clog2(NUM_WAYS)-1:0]   victim_way,
    output logic [CNT_W-1:0]              victim_count,
    output logic                          age_pulse,
    output logic [NUM_WAYS*CNT_W-1:0]     counts
);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int PAIRS = NUM_WAYS / 2;
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt     [NUM_WAYS];
    logic [CNT_W-1:0] w_cnt_nxt [NUM_WAYS];
    logic             w_sat_age;
    logic             w_per_age;
    logic             w_age;

    assign w_sat_age = hit_valid && (r_cnt[hit_way] == C_CNT_MAX);
    assign w_age     = w_sat_age || w_per_age;

    generate
        if (AGE_PERIOD > 0) begin : g_age_timer
            localparam int TMR_W = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
            localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(AGE_PERIOD - 1);
            logic [TMR_W-1:0] r_timer;

            assign w_per_age = (r_timer == C_TMR_LAST);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_timer <= '0;
                end else if (w_per_age) begin
                    r_timer <= '0;
                end else begin
                    r_timer <= r_timer + TMR_W'(1);
                end
            end
        end else begin : g_no_age_timer
            assign w_per_age = 1'b0;
        end
    endgenerate

    // Halve first, then increment the hit way; a fill overrides both.
    always_comb begin
        for (int i = 0; i < NUM_WAYS; i++) begin
            w_cnt_nxt[i] = w_age ? (r_cnt[i] >> 1) : r_cnt[i];
            if (hit_valid && (hit_way == WAY_W'(i))) begin
                w_cnt_nxt[i] = w_cnt_nxt[i] + CNT_W'(1);
            end
            if (fill_valid && (fill_way == WAY_W'(i))) begin
                w_cnt_nxt[i] = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                r_cnt[i] <= '0;
            end
            age_pulse <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            age_pulse <= w_age;
        end
    end

    // Stage 1: first tree level on the pre-update counters.
    logic [WAY_W-1:0] w_s1_way [PAIRS];
    logic [CNT_W-1:0] w_s1_cnt [PAIRS];
    logic [WAY_W-1:0] r_s1_way [PAIRS];
    logic [CNT_W-1:0] r_s1_cnt [PAIRS];
    logic             r_s1_valid;

    always_comb begin
        for (int j = 0; j < PAIRS; j++) begin
            if (r_cnt[2*j+1] < r_cnt[2*j]) begin
                w_s1_way[j] = WAY_W'(2*j+1);
                w_s1_cnt[j] = r_cnt[2*j+1];
            end else begin
                w_s1_way[j] = WAY_W'(2*j);
                w_s1_cnt[j] = r_cnt[2*j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            for (int j = 0; j < PAIRS; j++) begin
                r_s1_way[j] <= '0;
                r_s1_cnt[j] <= '0;
            end
        end else begin
            r_s1_valid <= victim_req;
            if (victim_req) begin
                for (int j = 0; j < PAIRS; j++) begin
                    r_s1_way[j] <= w_s1_way[j];
                    r_s1_cnt[j] <= w_s1_cnt[j];
                end
            end
        end
    end

    // Stage 2: pairs are index-ordered, so a strict compare keeps the lower way on ties.
    logic [WAY_W-1:0] w_min_way;
    logic [CNT_W-1:0] w_min_cnt;

    always_comb begin
        w_min_way = r_s1_way[0];
        w_min_cnt = r_s1_cnt[0];
        for (int j = 1; j < PAIRS; j++) begin
            if (r_s1_cnt[j] < w_min_cnt) begin
                w_min_way = r_s1_way[j];
                w_min_cnt = r_s1_cnt[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            victim_valid <= 1'b0;
            victim_way   <= '0;
            victim_count <= '0;
        end else begin
            victim_valid <= r_s1_valid;
            if (r_s1_valid) begin
                victim_way   <= w_min_way;
                victim_count <= w_min_cnt;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_WAYS; g++) begin : g_counts
            assign counts[g*CNT_W +: CNT_W] = r_cnt[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lfu_victim_select.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfu_victim_select
// Description : Self-checking bench with directed vector tables and a random
//               phase compared against a behavioural LFU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfu_victim_select;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hit_valid = 1'b0;
    logic [1:0]  hit_way = '0;
    logic        fill_valid = 1'b0;
    logic [1:0]  fill_way = '0;
    logic        victim_req = 1'b0;

    logic        vv0, age0, vv8, age8;
    logic [1:0]  vw0, vw8;
    logic [3:0]  vc0, vc8;
    logic [15:0] cnt0, cnt8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfu_victim_select #(.NUM_WAYS(4), .CNT_W(4), .AGE_PERIOD(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .hit_valid(hit_valid), .hit_way(hit_way),
        .fill_valid(fill_valid), .fill_way(fill_way),
        .victim_req(victim_req), .victim_valid(vv0), .victim_way(vw0),
        .victim_count(vc0), .age_pulse(age0), .counts(cnt0)
    );

    lfu_victim_select #(.NUM_WAYS(4), .CNT_W(4), .AGE_PERIOD(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .hit_valid(hit_valid), .hit_way(hit_way),
        .fill_valid(fill_valid), .fill_way(fill_way),
        .victim_req(victim_req), .victim_valid(vv8), .victim_way(vw8),
        .victim_count(vc8), .age_pulse(age8), .counts(cnt8)
    );

    typedef struct {
        logic        hv;
        logic [1:0]  hw;
        logic        fv;
        logic [1:0]  fw;
        logic        req;
        logic [15:0] cnt;
        logic        age;
        logic        vv;
        logic [1:0]  vw;
        logic [3:0]  vc;
    } row_t;

    row_t rows[$];

    // Reference model: index 0 has no periodic aging, index 1 ages every 8 cycles.
    int m_cnt [2][4];
    int m_tmr [2];
    bit m_age [2];
    bit m_pv [2];
    int m_pw [2];
    int m_pc [2];
    bit m_ov [2];
    int m_ow [2];
    int m_oc [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic hv, input logic [1:0] hw, input logic fv,
                                input logic [1:0] fw, input logic req, input logic [15:0] cnt,
                                input logic age, input logic vv, input logic [1:0] vw,
                                input logic [3:0] vc);
        row_t r;
        r.hv = hv; r.hw = hw; r.fv = fv; r.fw = fw; r.req = req;
        r.cnt = cnt; r.age = age; r.vv = vv; r.vw = vw; r.vc = vc;
        rows.push_back(r);
    endfunction

    task automatic drive(input logic hv, input logic [1:0] hw, input logic fv,
                         input logic [1:0] fw, input logic rq);
        hit_valid = hv; hit_way = hw; fill_valid = fv; fill_way = fw; victim_req = rq;
    endtask

    function automatic void model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) m_cnt[m][i] = 0;
            m_tmr[m] = 0; m_age[m] = 0;
            m_pv[m] = 0; m_pw[m] = 0; m_pc[m] = 0;
            m_ov[m] = 0; m_ow[m] = 0; m_oc[m] = 0;
        end
    endfunction

    function automatic void model_step(input bit hv, input int hw, input bit fv,
                                       input int fw, input bit rq);
        for (int m = 0; m < 2; m++) begin
            int  period;
            int  best;
            bit  sat;
            bit  per;
            period = (m == 0) ? 0 : 8;
            best = 0;
            for (int i = 1; i < 4; i++) if (m_cnt[m][i] < m_cnt[m][best]) best = i;
            m_ov[m] = m_pv[m]; m_ow[m] = m_pw[m]; m_oc[m] = m_pc[m];
            m_pv[m] = rq; m_pw[m] = best; m_pc[m] = m_cnt[m][best];
            sat = hv && (m_cnt[m][hw] == 15);
            per = (period > 0) && (m_tmr[m] == period - 1);
            if (period > 0) m_tmr[m] = per ? 0 : m_tmr[m] + 1;
            if (sat || per) for (int i = 0; i < 4; i++) m_cnt[m][i] = m_cnt[m][i] / 2;
            if (hv) m_cnt[m][hw] = m_cnt[m][hw] + 1;
            if (fv) m_cnt[m][fw] = 1;
            m_age[m] = sat || per;
        end
    endfunction

    function automatic logic [15:0] model_pack(input int m);
        logic [15:0] p;
        for (int i = 0; i < 4; i++) p[i*4 +: 4] = 4'(m_cnt[m][i]);
        return p;
    endfunction

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_clear();
        rst_n = 1'b1;
        chk("reset cnt0", 32'(cnt0), 32'h0);
        chk("reset cnt8", 32'(cnt8), 32'h0);
        chk("reset vv0", 32'(vv0), 32'h0);
        chk("reset age0", 32'(age0), 32'h0);
        chk("reset vw0", 32'(vw0), 32'h0);
        chk("reset vc0", 32'(vc0), 32'h0);
    endtask

    task automatic apply_rows(input int sel, input string tag);
        for (int k = 0; k < rows.size(); k++) begin
            logic [15:0] c;
            logic        a;
            logic        v;
            logic [1:0]  w;
            logic [3:0]  n;
            drive(rows[k].hv, rows[k].hw, rows[k].fv, rows[k].fw, rows[k].req);
            @(posedge clk);
            @(negedge clk);
            if (sel == 0) begin c = cnt0; a = age0; v = vv0; w = vw0; n = vc0; end
            else          begin c = cnt8; a = age8; v = vv8; w = vw8; n = vc8; end
            chk($sformatf("%s row%0d counts", tag, k), 32'(c), 32'(rows[k].cnt));
            chk($sformatf("%s row%0d age_pulse", tag, k), 32'(a), 32'(rows[k].age));
            chk($sformatf("%s row%0d victim_valid", tag, k), 32'(v), 32'(rows[k].vv));
            if (rows[k].vv) begin
                chk($sformatf("%s row%0d victim_way", tag, k), 32'(w), 32'(rows[k].vw));
                chk($sformatf("%s row%0d victim_count", tag, k), 32'(n), 32'(rows[k].vc));
            end
        end
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Directed vectors on the non-periodic instance; counts are {w3,w2,w1,w0}.
        rows.delete();
        add(0,0,0,0,1, 16'h0000,0,0,0,0);
        add(0,0,0,0,0, 16'h0000,0,1,0,0);
        add(0,0,0,0,0, 16'h0000,0,0,0,0);
        add(0,0,1,0,0, 16'h0001,0,0,0,0);
        add(0,0,1,1,0, 16'h0011,0,0,0,0);
        add(0,0,1,2,0, 16'h0111,0,0,0,0);
        add(0,0,1,3,0, 16'h1111,0,0,0,0);
        add(1,0,0,0,0, 16'h1112,0,0,0,0);
        add(1,0,0,0,0, 16'h1113,0,0,0,0);
        add(1,0,0,0,0, 16'h1114,0,0,0,0);
        add(1,1,0,0,0, 16'h1124,0,0,0,0);
        add(1,2,0,0,0, 16'h1224,0,0,0,0);
        add(1,2,0,0,0, 16'h1324,0,0,0,0);
        add(1,2,0,0,0, 16'h1424,0,0,0,0);
        add(1,2,0,0,0, 16'h1524,0,0,0,0);
        add(1,3,0,0,0, 16'h2524,0,0,0,0);
        add(1,3,0,0,0, 16'h3524,0,0,0,0);
        add(0,0,0,0,1, 16'h3524,0,0,0,0);
        add(0,0,0,0,0, 16'h3524,0,1,1,2);
        add(0,0,0,0,0, 16'h3524,0,0,0,0);
        add(0,0,1,2,0, 16'h3124,0,0,0,0);
        add(1,2,0,0,0, 16'h3224,0,0,0,0);
        add(0,0,1,0,0, 16'h3221,0,0,0,0);
        add(1,0,0,0,0, 16'h3222,0,0,0,0);
        add(1,0,0,0,0, 16'h3223,0,0,0,0);
        add(1,3,0,0,0, 16'h4223,0,0,0,0);
        add(1,3,0,0,0, 16'h5223,0,0,0,0);
        add(0,0,0,0,1, 16'h5223,0,0,0,0);
        add(0,0,0,0,1, 16'h5223,0,1,1,2);
        add(0,0,0,0,0, 16'h5223,0,1,1,2);
        add(0,0,0,0,0, 16'h5223,0,0,0,0);
        add(1,0,0,0,0, 16'h5224,0,0,0,0);
        add(0,0,1,3,0, 16'h1224,0,0,0,0);
        add(1,3,0,0,0, 16'h2224,0,0,0,0);
        add(1,3,0,0,0, 16'h3224,0,0,0,0);
        for (int k = 0; k < 13; k++) add(1,2,0,0,0, 16'h3224 + 16'((k+1) << 8),0,0,0,0);
        add(1,2,0,0,0, 16'h1812,1,0,0,0);
        add(0,0,0,0,1, 16'h1812,0,0,0,0);
        add(0,0,0,0,0, 16'h1812,0,1,1,1);
        add(0,0,0,0,0, 16'h1812,0,0,0,0);
        for (int k = 0; k < 8; k++) add(1,3,0,0,0, 16'h1812 + 16'((k+1) << 12),0,0,0,0);
        add(1,3,1,3,0, 16'h1812,0,0,0,0);
        add(1,1,0,0,0, 16'h1822,0,0,0,0);
        add(1,0,1,1,0, 16'h1813,0,0,0,0);
        add(1,1,0,0,1, 16'h1823,0,0,0,0);
        add(0,0,0,0,0, 16'h1823,0,1,1,1);
        add(0,0,0,0,0, 16'h1823,0,0,0,0);
        apply_rows(0, "lfu");

        // Periodic aging instance: aging lands on every 8th edge after reset release.
        do_reset();
        rows.delete();
        add(0,0,1,0,0, 16'h0001,0,0,0,0);
        add(1,0,1,1,0, 16'h0012,0,0,0,0);
        add(1,0,1,2,0, 16'h0113,0,0,0,0);
        add(1,0,1,3,0, 16'h1114,0,0,0,0);
        add(1,0,0,0,0, 16'h1115,0,0,0,0);
        add(1,0,0,0,0, 16'h1116,0,0,0,0);
        add(1,1,0,0,0, 16'h1126,0,0,0,0);
        add(1,0,1,2,0, 16'h0114,1,0,0,0);
        add(1,0,1,3,0, 16'h1115,0,0,0,0);
        add(1,0,0,0,0, 16'h1116,0,0,0,0);
        add(1,0,0,0,0, 16'h1117,0,0,0,0);
        add(1,1,0,0,0, 16'h1127,0,0,0,0);
        add(1,1,0,0,0, 16'h1137,0,0,0,0);
        add(1,1,0,0,0, 16'h1147,0,0,0,0);
        add(1,2,0,0,0, 16'h1247,0,0,0,0);
        add(0,0,0,0,0, 16'h0123,1,0,0,0);
        add(0,0,0,0,1, 16'h0123,0,0,0,0);
        apply_rows(1, "age");

        // A request is in flight; an asynchronous reset must drop it.
        rst_n = 1'b0;
        #1;
        chk("async reset cnt8", 32'(cnt8), 32'h0);
        chk("async reset cnt0", 32'(cnt0), 32'h0);
        chk("async reset vv8", 32'(vv8), 32'h0);
        chk("async reset age8", 32'(age8), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("post-reset vv8 cyc%0d", k), 32'(vv8), 32'h0);
            chk($sformatf("post-reset vv0 cyc%0d", k), 32'(vv0), 32'h0);
        end

        // Random traffic, hot on way 0 so saturation aging occurs regularly.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            bit          hv;
            bit          fv;
            bit          rq;
            logic [1:0]  hw;
            logic [1:0]  fw;
            logic [15:0] pc;
            hv = ($urandom_range(0, 9) < 7);
            hw = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            fv = ($urandom_range(0, 9) == 0);
            fw = 2'($urandom_range(0, 3));
            rq = ($urandom_range(0, 2) == 0);
            drive(hv, hw, fv, fw, rq);
            @(posedge clk);
            model_step(hv, int'(hw), fv, int'(fw), rq);
            @(negedge clk);
            pc = model_pack(0);
            chk($sformatf("rand%0d counts p0", k), 32'(cnt0), 32'(pc));
            chk($sformatf("rand%0d age p0", k), 32'(age0), 32'(m_age[0]));
            chk($sformatf("rand%0d valid p0", k), 32'(vv0), 32'(m_ov[0]));
            if (m_ov[0]) begin
                chk($sformatf("rand%0d way p0", k), 32'(vw0), 32'(m_ow[0]));
                chk($sformatf("rand%0d vcount p0", k), 32'(vc0), 32'(m_oc[0]));
            end
            pc = model_pack(1);
            chk($sformatf("rand%0d counts p8", k), 32'(cnt8), 32'(pc));
            chk($sformatf("rand%0d age p8", k), 32'(age8), 32'(m_age[1]));
            chk($sformatf("rand%0d valid p8", k), 32'(vv8), 32'(m_ov[1]));
            if (m_ov[1]) begin
                chk($sformatf("rand%0d way p8", k), 32'(vw8), 32'(m_ow[1]));
                chk($sformatf("rand%0d vcount p8", k), 32'(vc8), 32'(m_oc[1]));
            end
        end
        drive(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
